exc_flush_ctrl: RTL and testbench
=================================

EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h1c000000, fetch target after reset.
REQ-002 Parameter: FLUSH_CYCLES, 1, cycles flush_all stays high per event (legal range 1..15).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: wb_exc  in  1  WB exception, already qualified with WB valid.
REQ-006 Port: wb_ertn  in  1  WB ertn, already qualified with WB valid.
REQ-007 Port: csr_eentry  in  32  exception entry address from CSR file.
REQ-008 Port: csr_era  in  32  return address from CSR file.
REQ-009 Port: int_pending  in  1  enabled, unmasked interrupt pending (CSR-side AND of IS, LIE and IE).
REQ-010 Port: id_int_take  in  1  ID tagged a valid instruction with INT this cycle.
REQ-011 Port: if_redirect_ready  in  1  IF accepts redirect this cycle.
REQ-012 Port: flush_all  out  1  clear valid of IF/ID/EX/MEM/WB.
REQ-013 Port: redirect_valid  out  1  new fetch PC offered to IF.
REQ-014 Port: redirect_pc  out  32  new fetch PC.
REQ-015 Port: int_req  out  1  ID requested to tag next valid instruction with INT.
REQ-016 Port: exc_cnt  out  16  saturating count of accepted exceptions (ertn excluded).

Function
REQ-017 SHALL be an FSM with states BOOT, IDLE, FLUSH, REDIRECT.
REQ-018 BOOT: redirect_valid=1, redirect_pc=RESET_PC; go to IDLE on if_redirect_ready.
REQ-019 IDLE with wb_exc or wb_ertn in cycle N: flush_all=1 combinationally in N; target latched at edge ending N.
REQ-020 Target: csr_eentry if wb_exc, else csr_era; wb_exc wins when both high and the event counts as an exception.
REQ-021 FLUSH_CYCLES=1: IDLE goes directly to REDIRECT at N+1; otherwise FLUSH holds flush_all=1 for cycles N+1..N+FLUSH_CYCLES-1 via a 4-bit down-counter, then REDIRECT.
REQ-022 REDIRECT: redirect_valid=1, redirect_pc=latched target, held stable until if_redirect_ready; next state IDLE.
REQ-023 In REDIRECT, redirect_valid and if_redirect_ready high in the same cycle complete the handshake; redirect_valid=0 next cycle.
REQ-024 redirect_valid SHALL be 0 in IDLE and FLUSH; flush_all SHALL be 0 in BOOT and REDIRECT.
REQ-025 wb_exc and wb_ertn outside IDLE SHALL be ignored: no target change, no count.
REQ-026 exc_cnt increments by 1 per accepted exception and saturates at 16'hFFFF.
REQ-027 Internal flag int_inflight: set when int_req and id_int_take are both high; cleared on any accepted event.
REQ-028 int_req = int_pending & state==IDLE & ~wb_exc & ~wb_ertn & ~int_inflight, combinational.
REQ-029 id_int_take while int_req=0 SHALL be ignored.
REQ-030 Interrupt exception reaching WB follows REQ-019..REQ-022 like any exception.

Reset
REQ-031 reset high at an edge: state=BOOT, target=RESET_PC, flush counter=0, int_inflight=0, exc_cnt=0.
REQ-032 During reset cycles: flush_all=0, int_req=0, redirect_valid=1, redirect_pc=RESET_PC.
REQ-033 Reset asserted mid-FLUSH or mid-REDIRECT SHALL abandon the sequence and take effect at the next edge; the latched target is lost.

Verification
REQ-034 Release reset with if_redirect_ready=0 for 3 cycles, then 1 -> redirect_pc=32'h1c000000 held 4 cycles, then IDLE with redirect_valid=0.
REQ-035 IDLE, wb_exc=1 one cycle, csr_eentry=32'h1c008000, FLUSH_CYCLES=3, ready=1 -> flush_all high cycles N..N+2; redirect at N+3 to 32'h1c008000; exc_cnt=1.
REQ-036 wb_exc=wb_ertn=1 same cycle, csr_era=32'h1c000100 -> redirect_pc=csr_eentry; exc_cnt increments.
REQ-037 wb_ertn during REDIRECT with ready=0 -> target unchanged, exc_cnt unchanged, redirect_valid stays 1.
REQ-038 int_pending=1 in IDLE, id_int_take=1 -> int_req=0 next cycle until wb_exc is accepted; then int_req=0 during FLUSH and REDIRECT and 1 again in IDLE if int_pending=1.
REQ-039 Preload exc_cnt to 16'hFFFE, two exceptions -> 16'hFFFF after each; reset mid-REDIRECT -> BOOT with redirect_pc=32'h1c000000 next cycle.

Source files
------------

// File: rtl/exc_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// exc_flush_ctrl_if
// Purpose : Pipeline-control bundle between the exception/flush controller
//           and the fetch stage.
// Signals :
//   flush_all          ctrl -> pipe  clear valid of IF/ID/EX/MEM/WB
//   redirect_valid     ctrl -> IF    a new fetch PC is offered
//   redirect_pc[31:0]  ctrl -> IF    the new fetch PC
//   if_redirect_ready  IF -> ctrl    IF accepts the redirect this cycle
// Modports: master = controller side, slave = fetch/pipeline side.
// ---------------------------------------------------------------------------
interface exc_flush_ctrl_if;
    logic        flush_all;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_redirect_ready;

    modport master (
        output flush_all,
        output redirect_valid,
        output redirect_pc,
        input  if_redirect_ready
    );

    modport slave (
        input  flush_all,
        input  redirect_valid,
        input  redirect_pc,
        output if_redirect_ready
    );
endinterface

// File: rtl/exc_flush_ctrl.sv
// ---------------------------------------------------------------------------
// exc_flush_ctrl
// Purpose : Sequences pipeline flush and fetch redirect for exceptions and
//           ertn retiring in WB, issues the boot fetch after reset, and
//           arbitrates interrupt tagging in ID.
// Ports   :
//   clk, reset               clock; synchronous active-high reset
//   wb_exc, wb_ertn          WB exception / ertn (already WB-valid qualified)
//   csr_eentry, csr_era      exception entry / return address from CSR file
//   int_pending              enabled, unmasked interrupt pending
//   id_int_take              ID tagged a valid instruction with INT
//   int_req                  ask ID to tag its next valid instruction
//   exc_cnt[15:0]            saturating count of accepted exceptions
//   redir (master modport)   flush_all / redirect handshake to the pipeline
// Parameters:
//   RESET_PC      fetch target after reset
//   FLUSH_CYCLES  cycles flush_all stays high per event (1..15)
// ---------------------------------------------------------------------------
module exc_flush_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h1c000000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_exc,
    input  logic                    wb_ertn,
    input  logic [31:0]             csr_eentry,
    input  logic [31:0]             csr_era,
    input  logic                    int_pending,
    input  logic                    id_int_take,
    output logic                    int_req,
    output logic [15:0]             exc_cnt,
    exc_flush_ctrl_if.master        redir
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        IDLE     = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    // Cycles spent in FLUSH after the event cycle itself (which is IDLE).
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    state_t      state_out;
    logic        accept;
    logic [31:0] target;
    logic [3:0]  flush_cnt;
    logic        int_inflight;

    // Events are only honoured in IDLE; anywhere else they are dropped.
    assign accept = (state == IDLE) && (wb_exc || wb_ertn);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: begin
                if (redir.if_redirect_ready) state_nxt = IDLE;
            end
            IDLE: begin
                if (accept) state_nxt = (FLUSH_CYCLES == 1) ? REDIRECT : FLUSH;
            end
            FLUSH: begin
                if (flush_cnt <= 4'd1) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (redir.if_redirect_ready) state_nxt = IDLE;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // ---------------- outputs ----------------
    // While reset is held the outputs look like BOOT even before the first
    // reset edge has moved the state register there.
    always_comb begin
        state_out            = reset ? BOOT : state;
        redir.flush_all      = 1'b0;
        redir.redirect_valid = 1'b0;
        redir.redirect_pc    = target;
        int_req              = 1'b0;
        case (state_out)
            BOOT: begin
                redir.redirect_valid = 1'b1;
                redir.redirect_pc    = RESET_PC;
            end
            IDLE: begin
                // Flush is raised in the event cycle itself, not one later.
                redir.flush_all = wb_exc || wb_ertn;
                int_req         = int_pending && !wb_exc && !wb_ertn && !int_inflight;
            end
            FLUSH: begin
                redir.flush_all = 1'b1;
            end
            REDIRECT: begin
                redir.redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath: target, flush counter, INT flag, count ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            target       <= RESET_PC;
            flush_cnt    <= 4'd0;
            int_inflight <= 1'b0;
            exc_cnt      <= 16'd0;
        end else begin
            if (accept) begin
                // An exception outranks a simultaneous ertn.
                target       <= wb_exc ? csr_eentry : csr_era;
                flush_cnt    <= FLUSH_LOAD;
                int_inflight <= 1'b0;
                if (wb_exc && (exc_cnt != 16'hFFFF)) begin
                    exc_cnt <= exc_cnt + 16'd1;
                end
            end else begin
                if (state == FLUSH && flush_cnt != 4'd0) begin
                    flush_cnt <= flush_cnt - 4'd1;
                end
                // Once ID has tagged an instruction, stop asking until that
                // instruction's exception (or any other event) is accepted.
                if (int_req && id_int_take) begin
                    int_inflight <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_flush_ctrl
// Purpose : Self-checking bench for exc_flush_ctrl (FLUSH_CYCLES=3). Expected
//           redirect targets are queued when an event is driven and popped
//           when the redirect handshake completes.
// ---------------------------------------------------------------------------
module tb_exc_flush_ctrl;

    localparam logic [31:0] RESET_PC     = 32'h1c000000;
    localparam int unsigned FLUSH_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_exc;
    logic        wb_ertn;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        int_pending;
    logic        id_int_take;
    logic        int_req;
    logic [15:0] exc_cnt;

    exc_flush_ctrl_if ifc ();

    exc_flush_ctrl #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_exc      (wb_exc),
        .wb_ertn     (wb_ertn),
        .csr_eentry  (csr_eentry),
        .csr_era     (csr_era),
        .int_pending (int_pending),
        .id_int_take (id_int_take),
        .int_req     (int_req),
        .exc_cnt     (exc_cnt),
        .redir       (ifc.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] sb_q[$];
    logic [15:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called mid-cycle (inputs settled): checks any completing redirect
    // against the scoreboard, then moves to the next falling edge.
    task automatic advance();
        logic [31:0] e;
        #1;
        if (ifc.redirect_valid && ifc.if_redirect_ready) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEADBEEF;
            check("sb_redirect_pc", ifc.redirect_pc, e);
        end
        @(negedge clk);
    endtask

    // Event cycle N in IDLE: flush is immediate, no redirect, no INT request.
    task automatic do_event(input logic exc, input logic ertn,
                            input logic [31:0] eentry, input logic [31:0] era);
        wb_exc     = exc;
        wb_ertn    = ertn;
        csr_eentry = eentry;
        csr_era    = era;
        #1;
        check("ev_flush", ifc.flush_all, 1);
        check("ev_valid", ifc.redirect_valid, 0);
        check("ev_int_req", int_req, 0);
        sb_q.push_back(exc ? eentry : era);
        if (exc && exp_cnt != 16'hFFFF) exp_cnt++;
        advance();
    endtask

    // Cycles N+1 .. N+FLUSH_CYCLES-1; WB events here must be ignored.
    task automatic flush_tail();
        for (int i = 0; i < FLUSH_CYCLES - 1; i++) begin
            wb_exc     = 1'b1;
            wb_ertn    = 1'b1;
            csr_eentry = $urandom;
            csr_era    = $urandom;
            #1;
            check("fl_flush", ifc.flush_all, 1);
            check("fl_valid", ifc.redirect_valid, 0);
            check("fl_int_req", int_req, 0);
            advance();
        end
    endtask

    // REDIRECT with 'stall' cycles of ready=0 (events injected and ignored),
    // then the handshake, then one IDLE cycle.
    task automatic redirect_phase(input int stall);
        for (int i = 0; i < stall; i++) begin
            ifc.if_redirect_ready = 1'b0;
            wb_exc     = 1'b0;
            wb_ertn    = 1'b1;
            csr_era    = $urandom;
            csr_eentry = $urandom;
            #1;
            check("rd_hold_valid", ifc.redirect_valid, 1);
            check("rd_hold_pc", ifc.redirect_pc, (sb_q.size() != 0) ? sb_q[0] : 32'hDEADBEEF);
            check("rd_hold_flush", ifc.flush_all, 0);
            check("rd_hold_cnt", exc_cnt, exp_cnt);
            advance();
        end
        wb_exc  = 1'b0;
        wb_ertn = 1'b0;
        ifc.if_redirect_ready = 1'b1;
        #1;
        check("rd_valid", ifc.redirect_valid, 1);
        check("rd_flush", ifc.flush_all, 0);
        check("rd_int_req", int_req, 0);
        check("rd_cnt", exc_cnt, exp_cnt);
        advance();
        #1;
        check("idle_valid", ifc.redirect_valid, 0);
        check("idle_flush", ifc.flush_all, 0);
        check("idle_int_req", int_req, int_pending);
        advance();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        wb_exc      = 1'b1;
        wb_ertn     = 1'b0;
        csr_eentry  = 32'h0;
        csr_era     = 32'h0;
        int_pending = 1'b1;
        id_int_take = 1'b0;
        ifc.if_redirect_ready = 1'b0;
        exp_cnt     = 16'd0;

        // Reset cycles: BOOT-like outputs even with events and INT pending.
        @(negedge clk);
        #1;
        check("rst_flush", ifc.flush_all, 0);
        check("rst_int_req", int_req, 0);
        check("rst_valid", ifc.redirect_valid, 1);
        check("rst_pc", ifc.redirect_pc, RESET_PC);
        advance();
        wb_exc = 1'b0;
        advance();
        check("rst_exc_cnt", exc_cnt, 0);

        // Boot: ready low 3 cycles then high -> RESET_PC held 4 cycles.
        reset       = 1'b0;
        int_pending = 1'b0;
        sb_q.push_back(RESET_PC);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("boot_valid", ifc.redirect_valid, 1);
            check("boot_pc", ifc.redirect_pc, RESET_PC);
            check("boot_flush", ifc.flush_all, 0);
            advance();
        end
        ifc.if_redirect_ready = 1'b1;
        #1;
        check("boot_valid_hs", ifc.redirect_valid, 1);
        advance();
        #1;
        check("boot_idle_valid", ifc.redirect_valid, 0);
        advance();

        // Plain exception, FLUSH_CYCLES=3, ready high.
        do_event(1'b1, 1'b0, 32'h1c008000, 32'h1c000300);
        flush_tail();
        redirect_phase(0);
        check("cnt_after_exc", exc_cnt, 16'd1);

        // exc and ertn together: eentry wins and counts; ertn during a stalled
        // REDIRECT changes nothing.
        do_event(1'b1, 1'b1, 32'h1c004000, 32'h1c000100);
        flush_tail();
        redirect_phase(2);

        // ertn alone: return to era, no count.
        do_event(1'b0, 1'b1, 32'h1c00dead, 32'h1c000200);
        flush_tail();
        redirect_phase(1);

        // id_int_take without a request is ignored.
        int_pending = 1'b0;
        id_int_take = 1'b1;
        #1;
        check("int_req_off", int_req, 0);
        advance();
        int_pending = 1'b1;
        id_int_take = 1'b0;
        #1;
        check("int_req_on", int_req, 1);
        id_int_take = 1'b1;
        advance();
        id_int_take = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("int_inflight", int_req, 0);
            advance();
        end
        // Interrupt exception reaches WB; request returns in IDLE afterwards.
        do_event(1'b1, 1'b0, 32'h1c00a000, 32'h1c000400);
        flush_tail();
        redirect_phase(0);
        int_pending = 1'b0;

        // Counter saturation from a preloaded FFFE.
        force dut.exc_cnt = 16'hFFFE;
        advance();
        release dut.exc_cnt;
        exp_cnt = 16'hFFFE;
        #1;
        check("preload_cnt", exc_cnt, 16'hFFFE);
        for (int i = 0; i < 2; i++) begin
            do_event(1'b1, 1'b0, 32'h1c00b000 + 32'(i * 16), 32'h1c000500);
            flush_tail();
            redirect_phase(0);
            check("sat_cnt", exc_cnt, 16'hFFFF);
        end

        // Reset during a stalled REDIRECT abandons the latched target.
        do_event(1'b1, 1'b0, 32'h1c00c000, 32'h1c000600);
        flush_tail();
        wb_exc  = 1'b0;
        wb_ertn = 1'b0;
        ifc.if_redirect_ready = 1'b0;
        #1;
        check("pre_rst_pc", ifc.redirect_pc, 32'h1c00c000);
        reset = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_pc", ifc.redirect_pc, RESET_PC);
        advance();
        reset   = 1'b0;
        exp_cnt = 16'd0;
        sb_q.push_back(RESET_PC);
        #1;
        check("reboot_valid", ifc.redirect_valid, 1);
        check("reboot_pc", ifc.redirect_pc, RESET_PC);
        check("reboot_flush", ifc.flush_all, 0);
        check("reboot_cnt", exc_cnt, exp_cnt);
        ifc.if_redirect_ready = 1'b1;
        advance();
        #1;
        check("reboot_idle", ifc.redirect_valid, 0);
        advance();

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
